// File: rtl/dds_phase_engine.sv
// dds_phase_engine: converts a frequency word (Hz) into a DDS tuning word and integrates it into a phase accumulator.
// Latency: freq_in change sampled in IDLE -> tw_out updated FREQ_W+1 edges later (sync_update=0), or at the next accumulator wrap (sync_update=1).
// Backpressure: none; freq_in changes during a conversion are ignored and re-compared once back in IDLE.
//
// Ports: clk, rst_n (async active-low); freq_in, enable, phase_clr, sync_update in;
//        tw_out (active tuning word), tw_update (1-cycle pulse when tw_out changes), busy, phase_out out.
// Optional feature: define DDS_PHASE_DITHER_EN to add LFSR dither below the phase truncation point.
module dds_phase_engine #(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned FREQ_W  = 20,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned PHASE_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FREQ_W-1:0]  freq_in,
    input  logic               enable,
    input  logic               phase_clr,
    input  logic               sync_update,
    output logic [ACC_W-1:0]   tw_out,
    output logic               tw_update,
    output logic               busy,
    output logic [PHASE_W-1:0] phase_out
);

    localparam int unsigned PROD_W = 48;
    localparam int unsigned CNT_W  = (FREQ_W > 1) ? $clog2(FREQ_W) : 1;
    // K = round(2^48 / CLK_HZ); tuning word = round(freq * K / 2^16)
    localparam logic [PROD_W-1:0] K =
        PROD_W'(((64'd1 << 48) + 64'(CLK_HZ) / 64'd2) / 64'(CLK_HZ));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        LOAD = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [FREQ_W-1:0]  freq_lat;
    logic [FREQ_W-1:0]  fsh;
    logic [PROD_W-1:0]  ksh;
    logic [PROD_W-1:0]  prod;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   tw_pending;
    logic [ACC_W-1:0]   tw_calc;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W:0]     acc_sum;
    logic               carry;
    logic               start;
    logic               load_now;
    logic               apply_pend;

    // Extra top bit of the sum is the wrap carry that times synchronous updates.
    assign acc_sum = {1'b0, acc} + {1'b0, tw_out};
    assign carry   = enable & ~phase_clr & acc_sum[ACC_W];
    assign tw_calc = ACC_W'((prod + PROD_W'(32768)) >> 16);
    assign busy    = (state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        load_now   = 1'b0;
        apply_pend = 1'b0;
        case (state)
            IDLE: begin
                if (freq_in != freq_lat) begin
                    start     = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (cnt == CNT_W'(FREQ_W - 1)) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (!sync_update) begin
                    load_now  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A held or cleared accumulator may never wrap, so apply at once then.
                if (carry || !sync_update || !enable || phase_clr) begin
                    apply_pend = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- serial shift-add multiplier and tuning word ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_lat   <= '0;
            fsh        <= '0;
            ksh        <= '0;
            prod       <= '0;
            cnt        <= '0;
            tw_pending <= '0;
            tw_out     <= '0;
            tw_update  <= 1'b0;
        end else begin
            tw_update <= load_now | apply_pend;
            if (start) begin
                freq_lat <= freq_in;
                fsh      <= freq_in;
                ksh      <= K;
                prod     <= '0;
                cnt      <= '0;
            end
            if (state == MUL) begin
                if (fsh[0]) begin
                    prod <= prod + ksh;
                end
                ksh <= ksh << 1;
                fsh <= fsh >> 1;
                cnt <= cnt + CNT_W'(1);
            end
            if (state == LOAD) begin
                tw_pending <= tw_calc;
            end
            if (load_now) begin
                tw_out <= tw_calc;
            end else if (apply_pend) begin
                tw_out <= tw_pending;
            end
        end
    end

    // ---------------- phase accumulator ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (phase_clr) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc_sum[ACC_W-1:0];
        end
    end

`ifdef DDS_PHASE_DITHER_EN
    logic [15:0]      lfsr;
    logic [ACC_W-1:0] acc_dith;

    // Dither sits in bits [19:4], entirely below the 12-bit truncation point.
    assign acc_dith = acc + ACC_W'({lfsr, 4'b0000});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else if (enable) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_out <= '0;
        end else begin
            phase_out <= acc_dith[ACC_W-1 -: PHASE_W];
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_out <= '0;
        end else begin
            phase_out <= acc[ACC_W-1 -: PHASE_W];
        end
    end
`endif

endmodule

// File: tb/tb_dds_phase_engine.sv
// tb_dds_phase_engine: scoreboard bench for dds_phase_engine (default build, no dither).
// Expected tuning words are pushed when a frequency is driven and compared on each tw_update pulse.
// Also checks latency, synchronous wrap timing, accumulator hold/clear and async reset abort.
module tb_dds_phase_engine;

    logic        clk;
    logic        rst_n;
    logic [19:0] freq_in;
    logic        enable;
    logic        phase_clr;
    logic        sync_update;
    logic [31:0] tw_out;
    logic        tw_update;
    logic        busy;
    logic [11:0] phase_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    dds_phase_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .freq_in     (freq_in),
        .enable      (enable),
        .phase_clr   (phase_clr),
        .sync_update (sync_update),
        .tw_out      (tw_out),
        .tw_update   (tw_update),
        .busy        (busy),
        .phase_out   (phase_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: round(f * K / 2^16) with K = round(2^48 / 100 MHz) = 2814750.
    function automatic logic [31:0] tw_of(input logic [63:0] f);
        logic [63:0] p;
        p = f * 64'd2814750 + 64'd32768;
        return p[47:16];
    endfunction

    // Scoreboard: every tw_update pops the oldest expected tuning word.
    always @(negedge clk) begin
        if (rst_n && tw_update) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tw_update", 1, 0);
            end else begin
                check("tw_out", tw_out, exp_q.pop_front());
            end
        end
    end

    // Edges counted until tw_update is seen at a negedge; bounded.
    task automatic wait_update(input int bound, output int edges);
        bit done;
        edges = 0;
        done  = 1'b0;
        while (!done) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (tw_update) begin
                done = 1'b1;
            end else if (edges >= bound) begin
                check("timeout_tw_update", 0, 1);
                done = 1'b1;
            end
        end
    endtask

    task automatic convert(input logic [19:0] f, input string tag);
        int e;
        freq_in = f;
        exp_q.push_back(tw_of(f));
        wait_update(60, e);
        check(tag, e, 22);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int e;
        int pulses;
        bit done;
        logic [31:0] m_acc;
        logic [31:0] m_tw;
        logic [11:0] ph_exp;
        bit acc_v;
        bit ph_v;
        bit en_t[16]  = '{1,1,1,1,1,0,0,0,1,1,1,0,1,1,1,1};
        bit clr_t[16] = '{1,0,0,0,0,0,0,0,0,0,1,1,0,0,0,0};

        rst_n       = 1'b0;
        freq_in     = 20'd100000;
        enable      = 1'b1;
        phase_clr   = 1'b0;
        sync_update = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tw_out", tw_out, 0);
        check("rst_tw_update", tw_update, 0);
        check("rst_busy", busy, 0);
        check("rst_phase_out", phase_out, 0);

        // 1: first conversion straight out of reset
        exp_q.push_back(tw_of(100000));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t1_busy_edge1", busy, 1);
        wait_update(60, e);
        check("t1_latency", e + 1, 22);
        check("t1_busy_at_update", busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("t1_single_pulse", tw_update, 0);
        check("t1_tw_hold", tw_out, 32'd4294968);

        // 2: low and high frequencies
        convert(20'd1000, "t2_lat_1000");
        check("t2_tw_1000", tw_out, 32'd42950);
        convert(20'd999000, "t2_lat_999000");
        check("t2_tw_999000", tw_out, 32'd42906727);

        // 3: change during MUL is ignored, then converted afterwards
        freq_in = 20'd100000;
        exp_q.push_back(tw_of(100000));
        pulses = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        if (tw_update) pulses++;
        freq_in = 20'd200000;
        exp_q.push_back(tw_of(200000));
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (tw_update) pulses++;
        end
        check("t3_pulses", pulses, 2);
        check("t3_final_tw", tw_out, 32'd8589935);
        check("t3_idle", busy, 0);
        check("t3_queue_drained", exp_q.size(), 0);

        // 4: synchronous update lands on the accumulator wrap
        convert(20'd100000, "t4_lat_setup");
        sync_update = 1'b1;
        freq_in     = 20'd200000;
        exp_q.push_back(tw_of(200000));
        done = 1'b0;
        for (int i = 1; i <= 3000 && !done; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 10 || i == 22) begin
                check("t4_tw_held", tw_out, 32'd4294968);
                check("t4_busy", busy, 1);
            end
            if (tw_update) begin
                done = 1'b1;
                // phase_out lags acc by one cycle: it still shows the pre-wrap value here
                check("t4_pre_wrap", phase_out >= 12'd4091, 1);
                check("t4_not_early", i > 22, 1);
                @(posedge clk);
                @(negedge clk);
                check("t4_post_wrap", phase_out <= 12'd4, 1);
                check("t4_busy_done", busy, 0);
            end
        end
        if (!done) check("t4_timeout", 0, 1);
        sync_update = 1'b0;

        // 5: hold / clear behaviour against an accumulator model
        m_tw  = 32'd8589935;
        m_acc = 32'd0;
        acc_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enable    = en_t[i];
            phase_clr = clr_t[i];
            @(posedge clk);
            ph_exp = m_acc[31:20];
            ph_v   = acc_v;
            if (clr_t[i]) begin
                m_acc = 32'd0;
                acc_v = 1'b1;
            end else if (en_t[i]) begin
                m_acc = m_acc + m_tw;
            end
            @(negedge clk);
            if (ph_v) check($sformatf("t5_phase_%0d", i), phase_out, ph_exp);
        end
        enable    = 1'b1;
        phase_clr = 1'b0;

        // 6: async reset in the middle of MUL aborts, then reconverts
        freq_in = 20'd100000;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tw_out", tw_out, 0);
        check("t6_rst_tw_update", tw_update, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_phase_out", phase_out, 0);
        repeat (2) @(negedge clk);
        exp_q.push_back(tw_of(100000));
        rst_n = 1'b1;
        wait_update(60, e);
        check("t6_latency", e, 22);
        check("t6_tw", tw_out, 32'd4294968);
        repeat (3) @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
